// File: rtl/tile_memory_arbiter_if.sv
// Bus bundle between the tile-map arbiter, its three users (CPU, video, clear) and the RAM.
// The slave view belongs to the arbiter; the master view is everything around it.
interface tile_memory_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 7
);
  logic              cpu_valid;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_ready;
  logic [7:0]        cpu_rdata;

  logic              vid_ren;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;

  logic              clr_start;
  logic [DATA_W-1:0] clr_value;
  logic              clr_busy;

  logic              mem_wen;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_valid, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_rdata,
    input  vid_ren, vid_addr,
    output vid_rvalid, vid_rdata,
    input  clr_start, clr_value,
    output clr_busy,
    output mem_wen, mem_waddr, mem_wdata, mem_ren, mem_raddr,
    input  mem_rdata
  );

  modport master (
    output cpu_valid, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_rdata,
    output vid_ren, vid_addr,
    input  vid_rvalid, vid_rdata,
    output clr_start, clr_value,
    input  clr_busy,
    input  mem_wen, mem_waddr, mem_wdata, mem_ren, mem_raddr,
    output mem_rdata
  );
endinterface

// File: rtl/tile_memory_arbiter.sv
// Shares the two ports of the tile-map RAM between CPU, video fetcher and a fill engine.
// Video owns the read port; CPU reads use idle read cycles; CPU writes and clear share writes.
module tile_memory_arbiter #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 7
) (
  input logic                   clk,
  input logic                   resetn,
  tile_memory_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRdWait, StAck, StClear} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = '1;

  state_e            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] clr_val;
  logic              clr_pend;
  logic              cpu_ready_q;
  logic [7:0]        cpu_rdata_q;
  logic              vid_rvalid_q;

  logic              cpu_rd_issue;
  logic              cpu_wr_accept;

  assign cpu_rd_issue = (state == StIdle) & bus.cpu_valid & ~bus.cpu_we & ~bus.vid_ren
                        & ~clr_pend;
  // A clear requested in the same cycle holds the write back, so the fill cannot overwrite it.
  assign cpu_wr_accept = (state == StIdle) & bus.cpu_valid & bus.cpu_we & ~clr_pend
                         & ~bus.clr_start;

  always_comb begin
    bus.mem_ren   = resetn & (bus.vid_ren | cpu_rd_issue);
    bus.mem_raddr = bus.vid_ren ? bus.vid_addr : bus.cpu_addr;
    bus.mem_wen   = 1'b0;
    bus.mem_waddr = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_wdata;
    if (state == StClear) begin
      bus.mem_wen   = resetn;
      bus.mem_waddr = clr_cnt;
      bus.mem_wdata = 8'(clr_val);
    end else if (cpu_wr_accept) begin
      bus.mem_wen   = resetn;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= StIdle;
      clr_cnt      <= '0;
      clr_val      <= '0;
      clr_pend     <= 1'b0;
      cpu_ready_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      vid_rvalid_q <= 1'b0;
    end else begin
      cpu_ready_q  <= 1'b0;
      vid_rvalid_q <= bus.vid_ren;
      if (bus.clr_start && state != StClear) begin
        clr_pend <= 1'b1;
      end
      unique case (state)
        StIdle: begin
          if (clr_pend) begin
            state    <= StClear;
            clr_pend <= 1'b0;
            clr_val  <= bus.clr_value;
            clr_cnt  <= '0;
          end else if (cpu_wr_accept) begin
            state       <= StAck;
            cpu_ready_q <= 1'b1;
          end else if (cpu_rd_issue) begin
            state <= StRdWait;
          end
        end
        StRdWait: begin
          // RAM output here is the CPU result even if video issues a new read now.
          cpu_rdata_q <= 8'(bus.mem_rdata);
          cpu_ready_q <= 1'b1;
          state       <= StAck;
        end
        StAck: begin
          state <= StIdle;
        end
        StClear: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LastAddr) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.cpu_ready  = cpu_ready_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.vid_rvalid = vid_rvalid_q;
  assign bus.vid_rdata  = bus.mem_rdata;
  assign bus.clr_busy   = clr_pend | (state == StClear);

endmodule

// File: tb/tb_tile_memory_arbiter.sv
// Randomised bench for the tile-map arbiter: a RAM model on the memory side and a
// transaction-level golden map that every CPU and video read is compared against.
module tb_tile_memory_arbiter;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  tile_memory_arbiter_if #(.ADDR_W(12), .DATA_W(7)) bus ();

  tile_memory_arbiter #(.ADDR_W(12), .DATA_W(7)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // RAM: registered read with old-data-on-collision, bit 7 of write data dropped.
  logic [6:0] ram    [4096];
  logic [6:0] golden [4096];
  logic [6:0] ram_q;
  always @(posedge clk) begin
    if (bus.mem_ren) ram_q <= ram[bus.mem_raddr];
    if (bus.mem_wen) ram[bus.mem_waddr] <= bus.mem_wdata[6:0];
  end
  assign bus.mem_rdata = ram_q;

  // Video source: manual from the main sequence, or random lower-half reads.
  logic        vr_man, vr_rand, vr_rand_en;
  logic [11:0] va_man, va_rand;
  assign bus.vid_ren  = vr_rand_en ? vr_rand : vr_man;
  assign bus.vid_addr = vr_rand_en ? va_rand : va_man;

  always begin
    @(posedge clk);
    #1;
    vr_rand = 1'($urandom_range(0, 1));
    va_rand = 12'($urandom_range(0, 2047));
  end

  // Video checker: rvalid is ren one cycle later, data is the golden map entry.
  logic        vchk_en, vdata_en;
  logic        v_prev_ren;
  logic [11:0] v_prev_addr;
  always @(negedge clk) begin
    if (!resetn) begin
      v_prev_ren = 1'b0;
    end else begin
      if (vchk_en) check_eq("vid_rvalid", 32'(bus.vid_rvalid), 32'(v_prev_ren));
      if (vchk_en && vdata_en && v_prev_ren)
        check_eq("vid_rdata", 32'(bus.vid_rdata), 32'(golden[v_prev_addr]));
      v_prev_ren  = bus.vid_ren;
      v_prev_addr = bus.vid_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic        w0_wen;
  logic [11:0] w0_addr;
  logic [7:0]  w0_data;

  // One CPU transfer started at posedge+1; lat counts cycles from presentation to ready.
  task automatic cpu_xfer(input logic we, input logic [11:0] addr, input logic [7:0] wd,
                          output logic [7:0] rd, output int lat);
    bus.cpu_valid = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    lat = 0;
    @(negedge clk);
    w0_wen  = bus.mem_wen;
    w0_addr = bus.mem_waddr;
    w0_data = bus.mem_wdata;
    while (!bus.cpu_ready && lat < 10000) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.cpu_ready) check_eq("cpu_timeout", 32'd0, 32'd1);
    rd = bus.cpu_rdata;
    tick();
    bus.cpu_valid = 1'b0;
  endtask

  task automatic vid_sweep();
    vdata_en = 1'b1;
    for (int a = 0; a < 4096; a++) begin
      vr_man = 1'b1;
      va_man = 12'(a);
      tick();
    end
    vr_man = 1'b0;
    tick();
    tick();
    vdata_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_mem_wen"},    32'(bus.mem_wen),    32'd0);
    check_eq({tag, "_mem_ren"},    32'(bus.mem_ren),    32'd0);
    check_eq({tag, "_cpu_ready"},  32'(bus.cpu_ready),  32'd0);
    check_eq({tag, "_cpu_rdata"},  32'(bus.cpu_rdata),  32'd0);
    check_eq({tag, "_vid_rvalid"}, 32'(bus.vid_rvalid), 32'd0);
    check_eq({tag, "_clr_busy"},   32'(bus.clr_busy),   32'd0);
  endtask

  logic [7:0]  rd;
  int          lat, nw, busy_cyc, k;
  logic        issued, found;
  logic [11:0] ra;
  logic [7:0]  rw;
  logic        rwe;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]    = 7'(i);
      golden[i] = 7'(i);
    end
    vchk_en = 1'b0; vdata_en = 1'b0; vr_rand_en = 1'b0;
    vr_man = 1'b1; va_man = '0;
    bus.cpu_valid = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 12'h010; bus.cpu_wdata = 8'h7F;
    bus.clr_start = 1'b0; bus.clr_value = '0;
    resetn = 1'b0;

    // Reset: RAM strobes held off even with requests present.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    check_eq("rst_ram_untouched", 32'(ram[12'h010]), 32'h10);
    bus.cpu_valid = 1'b0;
    vr_man = 1'b0;
    tick();
    resetn = 1'b1;
    vchk_en = 1'b1;
    tick();

    // Write then read back 0x123.
    cpu_xfer(1'b1, 12'h123, 8'h55, rd, lat);
    check_eq("wr_mem_wen", 32'(w0_wen), 32'd1);
    check_eq("wr_mem_waddr", 32'(w0_addr), 32'h123);
    check_eq("wr_mem_wdata", 32'(w0_data), 32'h55);
    check_eq("wr_latency", 32'(lat), 32'd1);
    golden[12'h123] = 7'h55;
    @(negedge clk);
    check_eq("idle_mem_wen", 32'(bus.mem_wen), 32'd0);
    tick();
    cpu_xfer(1'b0, 12'h123, 8'h00, rd, lat);
    check_eq("rd_latency", 32'(lat), 32'd2);
    check_eq("rd_data", 32'(rd), 32'h55);

    // Video streaming over 0..99, back to back.
    vdata_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      vr_man = 1'b1;
      va_man = 12'(i);
      tick();
    end
    vr_man = 1'b0;
    tick();

    // CPU read held off by 10 video cycles; video read in RD_WAIT must not disturb it.
    vr_man = 1'b1; va_man = 12'h305;
    bus.cpu_valid = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h234;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("blk_raddr_vid", 32'(bus.mem_raddr), 32'h305);
      check_eq("blk_no_ready", 32'(bus.cpu_ready), 32'd0);
      tick();
    end
    vr_man = 1'b0;
    @(negedge clk);
    check_eq("blk_issue_ren", 32'(bus.mem_ren), 32'd1);
    check_eq("blk_issue_raddr", 32'(bus.mem_raddr), 32'h234);
    tick();
    vr_man = 1'b1;
    @(negedge clk);
    check_eq("blk_rdwait_ready", 32'(bus.cpu_ready), 32'd0);
    check_eq("blk_rdwait_wen", 32'(bus.mem_wen), 32'd0);
    tick();
    vr_man = 1'b0;
    @(negedge clk);
    check_eq("blk_ready", 32'(bus.cpu_ready), 32'd1);
    check_eq("blk_rdata", 32'(bus.cpu_rdata), 32'h34);
    tick();
    bus.cpu_valid = 1'b0;
    tick();

    // Random CPU traffic on the upper half against random video reads on the lower half.
    vr_rand_en = 1'b1;
    for (int t = 0; t < 150; t++) begin
      rwe = 1'($urandom_range(0, 1));
      ra  = 12'h800 | 12'($urandom_range(0, 2047));
      rw  = 8'($urandom);
      cpu_xfer(rwe, ra, rw, rd, lat);
      if (rwe) begin
        check_eq("rnd_wr_latency", 32'(lat), 32'd1);
        golden[ra] = rw[6:0];
      end else begin
        check_eq("rnd_rd_data", 32'(rd), 32'(golden[ra]));
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    vr_rand_en = 1'b0;
    tick();
    tick();
    vdata_en = 1'b0;

    // Full clear to 0x2A with a CPU write arriving mid-clear.
    bus.clr_start = 1'b1; bus.clr_value = 7'h2A;
    tick();
    bus.clr_start = 1'b0;
    nw = 0; busy_cyc = 0; issued = 1'b0;
    for (int t = 0; t < 6000; t++) begin
      @(negedge clk);
      if (!bus.clr_busy) break;
      busy_cyc++;
      if (bus.mem_wen) begin
        check_eq("clr_waddr", 32'(bus.mem_waddr), 32'(nw));
        check_eq("clr_wdata", 32'(bus.mem_wdata), 32'h2A);
        nw++;
      end
      if (issued) check_eq("clr_cpu_stall", 32'(bus.cpu_ready), 32'd0);
      tick();
      vr_man = 1'(t);
      va_man = 12'(t);
      if (nw == 1000 && !issued) begin
        bus.cpu_valid = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 12'h7F0; bus.cpu_wdata = 8'h91;
        issued = 1'b1;
      end
    end
    check_eq("clr_writes", 32'(nw), 32'd4096);
    check_eq("clr_busy_cycles", 32'(busy_cyc), 32'd4097);
    check_eq("post_clr_wen", 32'(bus.mem_wen), 32'd1);
    check_eq("post_clr_waddr", 32'(bus.mem_waddr), 32'h7F0);
    tick();
    vr_man = 1'b0;
    @(negedge clk);
    check_eq("post_clr_ready", 32'(bus.cpu_ready), 32'd1);
    tick();
    bus.cpu_valid = 1'b0;
    for (int i = 0; i < 4096; i++) golden[i] = 7'h2A;
    golden[12'h7F0] = 7'h11;
    tick();
    vid_sweep();

    // Clear request and CPU write in the same cycle: clear first, then the write.
    bus.clr_start = 1'b1; bus.clr_value = 7'h0F;
    bus.cpu_valid = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 12'h456; bus.cpu_wdata = 8'h66;
    @(negedge clk);
    check_eq("coll_wr_held", 32'(bus.mem_wen), 32'd0);
    tick();
    bus.clr_start = 1'b0;
    k = 0; found = 1'b0;
    for (int t = 0; t < 6000; t++) begin
      @(negedge clk);
      if (bus.cpu_ready) begin
        found = 1'b1;
        break;
      end
      k++;
    end
    check_eq("coll_ready_seen", 32'(found), 32'd1);
    check_eq("coll_ready_cycle", 32'(k), 32'd4098);
    check_eq("coll_busy_done", 32'(bus.clr_busy), 32'd0);
    tick();
    bus.cpu_valid = 1'b0;
    for (int i = 0; i < 4096; i++) golden[i] = 7'h0F;
    golden[12'h456] = 7'h66;
    tick();
    vid_sweep();

    // Reset while the fill is about to write address 2000.
    bus.clr_start = 1'b1; bus.clr_value = 7'h15;
    tick();
    bus.clr_start = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 6000; t++) begin
      @(negedge clk);
      if (bus.mem_wen && bus.mem_waddr == 12'd2000) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("rst_mid_found", 32'(found), 32'd1);
    resetn = 1'b0;
    bus.cpu_valid = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 12'h900;
    vr_man = 1'b1;
    #1;
    check_reset_outputs("rstclr");
    tick();
    check_reset_outputs("rstclr_hold");
    bus.cpu_valid = 1'b0;
    vr_man = 1'b0;
    tick();
    resetn = 1'b1;
    @(negedge clk);
    check_eq("rstclr_idle_busy", 32'(bus.clr_busy), 32'd0);
    check_eq("rstclr_idle_wen", 32'(bus.mem_wen), 32'd0);
    for (int i = 0; i < 2000; i++) golden[i] = 7'h15;
    tick();
    vid_sweep();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
